// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Contents: datapath width, funct3 op encodings, the controller state enum and
// helpers that decide operand signedness and operand magnitudes.
package mul_div_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  // Value the shared 6-bit iteration counter holds during the last divide step
  localparam logic [5:0] DivLastCnt = 6'(XLEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMulWait,
    StDivRun,
    StDivFix,
    StDone
  } state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

  // Unsigned magnitude; the most negative value maps to itself, which is the
  // correct unsigned magnitude 2^(XLEN-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] val, input logic neg);
    return neg ? -val : val;
  endfunction

endpackage

// File: rtl/mul_div_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   start                 load dividend/divisor and begin (ignored while kill)
//   kill                  abandon the running division
//   dividend, divisor     unsigned operands sampled on start
//   quotient, remainder   results, final once done pulses
//   done                  one-cycle pulse after the XLEN-th iteration
module mul_div_divider
  import mul_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            run_q, run_d, done_q, done_d;
  logic [XLEN:0]   shifted, diff;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (kill) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q == DivLastCnt) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/mul_div_ctrl.sv
// RV32M execute-unit sequencer: accepts M-extension requests, drives an external
// fixed-latency unsigned multiplier with operand magnitudes, runs the iterative
// divider, applies sign fix-ups and special divide cases, returns tagged results.
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   req_valid/req_ready               request handshake (req_op funct3, rs1, rs2, rd)
//   flush                             kill the in-flight op, no response produced
//   resp_valid/resp_ready             response handshake (resp_data, resp_rd)
//   busy                              controller not idle
//   mul_a, mul_b / mul_p              registered multiplier operands / 64-bit product
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              busy,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic [2*XLEN-1:0] mul_p
);

  localparam logic [5:0]      MulLastCnt = 6'(MUL_LAT);
  localparam logic [XLEN-1:0] MinInt     = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, data_q, data_d;
  logic            valid_q, valid_d;

  logic            sign1, sign2, accept, div_start, div_kill, div_done;
  logic            special_zero, special_ovf;
  logic [XLEN-1:0] mag1, mag2, div_quo, div_rem, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;

  assign sign1        = rs1_signed(req_op) & req_rs1[XLEN-1];
  assign sign2        = rs2_signed(req_op) & req_rs2[XLEN-1];
  assign mag1         = magnitude(req_rs1, sign1);
  assign mag2         = magnitude(req_rs2, sign2);
  assign special_zero = (req_rs2 == '0);
  assign special_ovf  = rs2_signed(req_op) && (req_rs1 == MinInt) && (req_rs2 == '1);

  // A special divide enters DONE one cycle before its result is presented, so
  // the response handshake (and back-to-back issue) waits for valid_q.
  assign req_ready = ((state_q == StIdle) || ((state_q == StDone) && valid_q && resp_ready))
                     && !flush;
  assign accept    = req_valid && req_ready;

  assign prod_fix = qneg_q ? -mul_p : mul_p;
  assign quo_fix  = qneg_q ? -div_quo : div_quo;
  assign rem_fix  = rneg_q ? -div_rem : div_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    data_d    = data_q;
    valid_d   = valid_q;
    div_start = 1'b0;
    div_kill  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StMulWait: begin
        // Counter restarts at every accept, so stale products from a flushed
        // op are never sampled.
        if (cnt_q == MulLastCnt) begin
          data_d  = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDivRun: begin
        if (cnt_q == DivLastCnt) begin
          cnt_d   = '0;
          state_d = StDivFix;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDivFix: begin
        if (div_done) begin
          data_d  = op_q[1] ? rem_fix : quo_fix;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d    = req_op;
      rd_d    = req_rd;
      cnt_d   = '0;
      qneg_d  = sign1 ^ sign2;
      rneg_d  = sign1;
      valid_d = 1'b0;
      if (!req_op[2]) begin
        mul_a_d = mag1;
        mul_b_d = mag2;
        state_d = StMulWait;
      end else if (special_zero) begin
        data_d  = req_op[1] ? req_rs1 : '1;
        state_d = StDone;
      end else if (special_ovf) begin
        data_d  = req_op[1] ? '0 : MinInt;
        state_d = StDone;
      end else begin
        div_start = 1'b1;
        state_d   = StDivRun;
      end
    end

    if (flush) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      cnt_d     = '0;
      div_start = 1'b0;
      div_kill  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  mul_div_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .kill      (div_kill),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign busy       = (state_q != StIdle);
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl with a behavioural 3-stage multiplier model.
module tb_mul_div_ctrl;

  localparam int unsigned MulLat = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data, mul_a, mul_b;
  logic [4:0]  resp_rd;
  logic [63:0] mul_p;
  logic [63:0] pipe [MulLat];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < MulLat; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[MulLat-1];

  mul_div_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check operands, latency, busy, result and the response handshake.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                       input int exp_lat, input logic [31:0] exp_ma, input logic [31:0] exp_mb);
    int   lat;
    logic busy_ok;
    req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
    #1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!op[2]) begin
      chk({tag, ".mul_a"}, 64'(mul_a), 64'(exp_ma));
      chk({tag, ".mul_b"}, 64'(mul_b), 64'(exp_mb));
    end
    lat = 0;
    busy_ok = 1'b1;
    while (!resp_valid && lat < 100) begin
      busy_ok &= busy;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    chk({tag, ".data"}, 64'(resp_data), 64'(exp_data));
    chk({tag, ".rd"}, 64'(resp_rd), 64'(rd));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic ok;
    int   lat;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.mul_a", 64'(mul_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd1);

    // Multiplies: latency MUL_LAT+1
    do_op("mul",    3'd0, 32'hFFFF_FFFF, 32'd2,        5'd1, 32'hFFFF_FFFE, 4,
          32'hFFFF_FFFF, 32'd2);
    do_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2,        5'd2, 32'hFFFF_FFFF, 4, 32'd1, 32'd2);
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 4,
          32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // rs2 is unsigned for MULHSU, so its magnitude is the raw value
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 4,
          32'd1, 32'hFFFF_FFFF);

    // Iterative divides: latency 33
    do_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 32'd0, 32'd0);
    do_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 32'd0, 32'd0);
    do_op("divu", 3'd5, 32'd100,       32'd7, 5'd7, 32'd14,        33, 32'd0, 32'd0);
    do_op("remu", 3'd7, 32'd100,       32'd7, 5'd8, 32'd2,         33, 32'd0, 32'd0);

    // Special divides: latency 1
    do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd9,  32'hFFFF_FFFF, 1, 32'd0, 32'd0);
    do_op("remu0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5,         1, 32'd0, 32'd0);
    do_op("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 32'd0, 32'd0);
    do_op("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1, 32'd0, 32'd0);

    // Backpressure: MUL 6*7 held for 5 cycles, then back-to-back with DIVU 5/0
    req_op = 3'd0; req_rs1 = 32'd6; req_rs2 = 32'd7; req_rd = 5'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 64'(lat), 64'd4);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      ok &= resp_valid && (resp_data == 32'd42) && (resp_rd == 5'd9) && !req_ready;
    end
    chk("bp.stable", 64'(ok), 64'd1);
    req_op = 3'd5; req_rs1 = 32'd5; req_rs2 = 32'd0; req_rd = 5'd10; req_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("bp.req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    chk("bp.new_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("bp.new_valid", 64'(resp_valid), 64'd1);
    chk("bp.new_data", 64'(resp_data), 64'hFFFF_FFFF);
    chk("bp.new_rd", 64'(resp_rd), 64'd10);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp.idle", 64'(busy), 64'd0);

    // Flush with nothing in flight only masks req_ready
    flush = 1'b1;
    #1;
    chk("idleflush.req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("idleflush.after", 64'(req_ready), 64'd1);

    // Flush in divide iteration 10, then a MUL at normal latency
    req_op = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("flush.req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.valid", 64'(resp_valid), 64'd0);
    do_op("postflush", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 4, 32'd3, 32'd4);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      ok &= !resp_valid;
    end
    chk("flush.no_resp", 64'(ok), 64'd1);

    // Reset in the middle of MUL_WAIT
    req_op = 3'd0; req_rs1 = 32'd5; req_rs2 = 32'd5; req_rd = 5'd13; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.data", 64'(resp_data), 64'd0);
    chk("midrst.rd", 64'(resp_rd), 64'd0);
    chk("midrst.mul_a", 64'(mul_a), 64'd0);
    chk("midrst.mul_b", 64'(mul_b), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      ok &= !resp_valid && !busy;
    end
    chk("midrst.no_resp", 64'(ok), 64'd1);
    chk("midrst.req_ready", 64'(req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
